// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: conditions raw lines, deframes 11-bit frames,
// decodes E0-prefixed arrow keys into held levels and press pulses.
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_up,
  output logic       o_down,
  output logic       o_left,
  output logic       o_right,
  output logic       o_up_pos,
  output logic       o_down_pos,
  output logic       o_left_pos,
  output logic       o_right_pos
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_PAR, S_STOP
  } state_t;

  logic [1:0]    r_clk_s, r_dat_s;
  logic [FW-1:0] r_clk_cnt, r_dat_cnt;
  logic          r_clk_f, r_dat_f, r_clk_prev;
  state_t        r_state, w_next;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tmo;
  logic          w_fall, w_tmo;
  logic          w_ok, w_perr, w_ferr;
  logic [7:0]    r_byte;
  logic          r_byte_valid, r_perr, r_ferr;
  logic          r_e0, r_f0;
  logic          r_up, r_down, r_left, r_right;
  logic          r_up_pos, r_down_pos, r_left_pos, r_right_pos;

  assign w_fall = r_clk_prev & ~r_clk_f;
  assign w_tmo  = (r_state != S_IDLE) && !w_fall &&
                  (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  // Synchronize both lines and accept a level only after a stable run
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_s    <= 2'b11;
      r_dat_s    <= 2'b11;
      r_clk_f    <= 1'b1;
      r_dat_f    <= 1'b1;
      r_clk_prev <= 1'b1;
      r_clk_cnt  <= '0;
      r_dat_cnt  <= '0;
    end else begin
      r_clk_s    <= {r_clk_s[0], i_ps2_clk};
      r_dat_s    <= {r_dat_s[0], i_ps2_dat};
      r_clk_prev <= r_clk_f;
      if (r_clk_s[1] == r_clk_f) begin
        r_clk_cnt <= '0;
      end else if (r_clk_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_f   <= r_clk_s[1];
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + FW'(1);
      end
      if (r_dat_s[1] == r_dat_f) begin
        r_dat_cnt <= '0;
      end else if (r_dat_cnt == FW'(FILTER_LEN - 1)) begin
        r_dat_f   <= r_dat_s[1];
        r_dat_cnt <= '0;
      end else begin
        r_dat_cnt <= r_dat_cnt + FW'(1);
      end
    end
  end

  // Frame state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Frame next-state: advances on clock falls, aborts on timeout
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_fall && !r_dat_f) w_next = S_DATA;
      S_DATA: begin
        if (w_fall && r_bitcnt == 3'd7) w_next = S_PAR;
        else if (w_tmo)                 w_next = S_IDLE;
      end
      S_PAR: begin
        if (w_fall)     w_next = S_STOP;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_STOP: if (w_fall || w_tmo) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame outcome: exactly one of ok / parity / framing per frame end
  always_comb begin
    w_ok   = 1'b0;
    w_perr = 1'b0;
    w_ferr = w_tmo;
    unique case (r_state)
      S_IDLE: if (w_fall && r_dat_f) w_ferr = 1'b1;
      S_STOP: begin
        if (w_fall) begin
          if (!r_dat_f)               w_ferr = 1'b1;
          else if (!(^{r_shift, r_par})) w_perr = 1'b1;
          else                        w_ok   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Shift register, bit counter, parity capture and inter-edge timer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tmo    <= '0;
    end else begin
      if (w_fall || w_next == S_IDLE) r_tmo <= '0;
      else                            r_tmo <= r_tmo + TW'(1);
      if (w_fall) begin
        unique case (r_state)
          S_IDLE: r_bitcnt <= '0;
          S_DATA: begin
            r_shift  <= {r_dat_f, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          S_PAR:   r_par <= r_dat_f;
          default: ;
        endcase
      end
    end
  end

  // Registered frame result pulses and received byte
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
    end else begin
      r_byte_valid <= w_ok;
      r_perr       <= w_perr;
      r_ferr       <= w_ferr;
      if (w_ok) r_byte <= r_shift;
    end
  end

  // Scan decoder: prefix flags, held arrow levels, press pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {r_e0, r_f0} <= 2'b00;
      {r_up, r_down, r_left, r_right} <= 4'b0;
      {r_up_pos, r_down_pos, r_left_pos, r_right_pos} <= 4'b0;
    end else begin
      {r_up_pos, r_down_pos, r_left_pos, r_right_pos} <= 4'b0;
      if (r_byte_valid) begin
        if (r_byte == 8'hE0) begin
          r_e0 <= 1'b1;
        end else if (r_byte == 8'hF0) begin
          r_f0 <= 1'b1;
        end else begin
          r_e0 <= 1'b0;
          r_f0 <= 1'b0;
          if (r_e0) begin
            unique case (r_byte)
              8'h75: begin
                r_up     <= !r_f0;
                r_up_pos <= !r_f0 && !r_up;
              end
              8'h72: begin
                r_down     <= !r_f0;
                r_down_pos <= !r_f0 && !r_down;
              end
              8'h6B: begin
                r_left     <= !r_f0;
                r_left_pos <= !r_f0 && !r_left;
              end
              8'h74: begin
                r_right     <= !r_f0;
                r_right_pos <= !r_f0 && !r_right;
              end
              default: ;
            endcase
          end
        end
      end else if (r_perr || r_ferr) begin
        r_e0 <= 1'b0;
        r_f0 <= 1'b0;
      end
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;
  assign o_up         = r_up;
  assign o_down       = r_down;
  assign o_left       = r_left;
  assign o_right      = r_right;
  assign o_up_pos     = r_up_pos;
  assign o_down_pos   = r_down_pos;
  assign o_left_pos   = r_left_pos;
  assign o_right_pos  = r_right_pos;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: directed scenarios then random key
// traffic, scored against a frame-level keyboard model.
module tb_ps2_key_receiver;

  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pc  = 1'b1;
  logic       pd  = 1'b1;
  logic [7:0] o_byte;
  logic       o_byte_valid, o_parity_err, o_frame_err;
  logic       o_up, o_down, o_left, o_right;
  logic       o_up_pos, o_down_pos, o_left_pos, o_right_pos;

  ps2_key_receiver #(
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_ps2_clk(pc),
    .i_ps2_dat(pd),
    .o_byte(o_byte),
    .o_byte_valid(o_byte_valid),
    .o_parity_err(o_parity_err),
    .o_frame_err(o_frame_err),
    .o_up(o_up),
    .o_down(o_down),
    .o_left(o_left),
    .o_right(o_right),
    .o_up_pos(o_up_pos),
    .o_down_pos(o_down_pos),
    .o_left_pos(o_left_pos),
    .o_right_pos(o_right_pos)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0;
  int n_pos[4] = '{0, 0, 0, 0};
  int last_valid = -10;
  int ferr_cyc = 0;
  int last_fall = 0;
  int hp = 20;

  logic [7:0] m_byte = 8'h00;
  bit         m_lvl[4] = '{0, 0, 0, 0};
  int         m_pos[4] = '{0, 0, 0, 0};
  int         e_valid = 0, e_perr = 0, e_ferr = 0;
  logic [7:0] pre[$];
  logic [7:0] codes[4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

  function automatic void chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Pulse counters; each press pulse must follow its byte by one cycle
  always @(negedge clk) begin
    if (o_up_pos) begin
      n_pos[0]++; chk("up_pos_lat", cyc - last_valid, 1);
    end
    if (o_down_pos) begin
      n_pos[1]++; chk("down_pos_lat", cyc - last_valid, 1);
    end
    if (o_left_pos) begin
      n_pos[2]++; chk("left_pos_lat", cyc - last_valid, 1);
    end
    if (o_right_pos) begin
      n_pos[3]++; chk("right_pos_lat", cyc - last_valid, 1);
    end
    if (o_byte_valid) begin
      n_valid++; last_valid = cyc;
    end
    if (o_parity_err) n_perr++;
    if (o_frame_err) begin
      n_ferr++; ferr_cyc = cyc;
    end
  end

  // kind: 0 good, 1 parity error, 2 stop error, 3 timeout
  task automatic m_frame(input logic [7:0] b, input int kind);
    bit has_e0, has_f0;
    has_e0 = 0;
    has_f0 = 0;
    if (kind != 0) begin
      if (kind == 1) e_perr++;
      else           e_ferr++;
      pre.delete();
    end else begin
      e_valid++;
      m_byte = b;
      if (b == 8'hE0 || b == 8'hF0) begin
        pre.push_back(b);
      end else begin
        foreach (pre[i]) begin
          if (pre[i] == 8'hE0) has_e0 = 1;
          if (pre[i] == 8'hF0) has_f0 = 1;
        end
        for (int d = 0; d < 4; d++) begin
          if (has_e0 && b == codes[d]) begin
            if (!has_f0 && !m_lvl[d]) m_pos[d]++;
            m_lvl[d] = !has_f0;
          end
        end
        pre.delete();
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ":byte"}, int'(o_byte), int'(m_byte));
    chk({tag, ":nvalid"}, n_valid, e_valid);
    chk({tag, ":nperr"}, n_perr, e_perr);
    chk({tag, ":nferr"}, n_ferr, e_ferr);
    chk({tag, ":levels"}, int'({o_up, o_down, o_left, o_right}),
        int'({m_lvl[0], m_lvl[1], m_lvl[2], m_lvl[3]}));
    for (int d = 0; d < 4; d++)
      chk($sformatf("%s:npos%0d", tag, d), n_pos[d], m_pos[d]);
  endtask

  task automatic put_bit(input logic v);
    pd = v;
    repeat (hp) @(negedge clk);
    pc = 1'b0;
    last_fall = cyc;
    repeat (hp) @(negedge clk);
    pc = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int kind, input string tag);
    logic par, stp;
    par = (kind == 1) ? ^b : ~^b;
    stp = (kind == 2) ? 1'b0 : 1'b1;
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
    put_bit(par);
    put_bit(stp);
    pd = 1'b1;
    repeat (30) @(negedge clk);
    m_frame(b, kind);
    compare(tag);
  endtask

  task automatic key(input int d, input bit brk, input string tag);
    send(8'hE0, 0, tag);
    if (brk) send(8'hF0, 0, tag);
    send(codes[d], 0, tag);
  endtask

  initial begin
    int f0, dly, r, d;
    logic [7:0] rb;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    compare("reset");
    chk("reset_pulses",
        int'({o_byte_valid, o_parity_err, o_frame_err,
              o_up_pos, o_down_pos, o_left_pos, o_right_pos}), 0);

    key(0, 0, "up_make");
    repeat (3) key(0, 0, "up_repeat");
    key(0, 1, "up_break");

    send(8'h6B, 1, "par_err");
    key(2, 0, "left_make");

    put_bit(1'b0);
    for (int i = 0; i < 4; i++) put_bit(1'($urandom_range(0, 1)));
    pd = 1'b1;
    f0 = n_ferr;
    for (int k = 0; k < TMO + 200; k++) begin
      @(negedge clk);
      if (n_ferr != f0) break;
    end
    dly = ferr_cyc - last_fall;
    chk("tmo_count", n_ferr - f0, 1);
    chk("tmo_delay_ok", int'(dly >= TMO && dly <= TMO + 30), 1);
    repeat (10) @(negedge clk);
    m_frame(8'h00, 3);
    compare("timeout");
    send(8'h1C, 0, "after_tmo");

    repeat (5) begin
      repeat (20) @(negedge clk);
      pc = 1'b0;
      repeat (3) @(negedge clk);
      pc = 1'b1;
    end
    repeat (30) @(negedge clk);
    compare("glitch");
    send(8'h29, 2, "stop_err");

    key(1, 0, "down_make");
    key(3, 0, "right_make");
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs",
        int'({o_byte, o_byte_valid, o_parity_err, o_frame_err,
              o_up, o_down, o_left, o_right,
              o_up_pos, o_down_pos, o_left_pos, o_right_pos}), 0);
    pd = 1'b1;
    m_byte = 8'h00;
    for (int i = 0; i < 4; i++) m_lvl[i] = 0;
    pre.delete();
    repeat (30) @(negedge clk);
    compare("post_rst");
    key(1, 0, "down_after_rst");

    for (int n = 0; n < 25; n++) begin
      hp = $urandom_range(12, 24);
      r  = $urandom_range(0, 99);
      d  = $urandom_range(0, 3);
      rb = 8'($urandom_range(0, 255));
      if (r < 10) begin
        send(rb, 1, "rnd_perr");
      end else if (r < 15) begin
        send(rb, 2, "rnd_ferr");
      end else if (r < 25) begin
        send(rb, 0, "rnd_byte");
      end else if (r < 35) begin
        send(8'hE0, 0, "rnd_abort");
        send(codes[d], 1, "rnd_abort");
        send(codes[d], 0, "rnd_abort");
      end else begin
        key(d, 1'($urandom_range(0, 1)), "rnd_key");
      end
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
